sar_search: RTL
===============

# sar_search

Successive-approximation search controller that sits on the operand side of the lab's magnitude comparator. It drives a trial value onto the comparator's A input, with the unknown target wired to B. It reads back the greater/equal/less flags each cycle and converges on the target bit by bit, MSB first. It reports the recovered value, the probe count, and a fault flag if the comparator answer is not one-hot.

## Interface
- WIDTH, default 4: operand width in bits; must match the comparator width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a search; honoured only in IDLE or DONE.
- cmp_gt  in  1  comparator result: guess > target, valid in the same cycle as guess.
- cmp_eq  in  1  comparator result: guess == target.
- cmp_lt  in  1  comparator result: guess < target.
- guess  out  WIDTH  trial value driven to the comparator; 0 when not in PROBE.
- guess_vld  out  1  high exactly while in PROBE.
- busy  out  1  high in PROBE.
- done  out  1  one-cycle pulse when a search ends, normally or on fault.
- result  out  WIDTH  recovered target; held from the done pulse until the next accepted start.
- probes  out  $clog2(WIDTH+1)  number of PROBE cycles used by the last search; held with result.
- err  out  1  set when the search ended on a non-one-hot comparator answer; held with result.

## Operation
- Reset values: all outputs are 0; state is IDLE; the internal accumulator acc, bit index k and counter are 0.
- IDLE, with start:
  - acc <= 0, k <= WIDTH-1, probe counter <= 0.
  - Clear result, probes and err.
  - Go to PROBE.
- PROBE:
  - guess = acc | (1 << k), combinational from registers.
  - The probe counter increments on every PROBE cycle.
  - Decision on the comparator flags, sampled at the clock edge ending the cycle:
    - If exactly cmp_eq: result <= guess and go to DONE.
    - If exactly cmp_gt: acc is unchanged, so the trial bit is dropped.
    - If exactly cmp_lt: acc <= guess, so the trial bit is kept.
    - On gt or lt with k == 0: result <= the updated acc and go to DONE. Otherwise k <= k-1 and stay in PROBE.
    - If zero or more than one flag is high: err <= 1, result <= acc (partial value), go to DONE.
- DONE:
  - done is high for the single cycle of entry only.
  - result, probes and err hold.
  - start goes to PROBE with the same initialisation as from IDLE. Otherwise remain in DONE.
  - DONE is otherwise equivalent to IDLE.
- start while busy is ignored; there is no restart mid-search.
- Target 0 is never hit by cmp_eq (guess is never 0). It terminates after WIDTH probes with result 0 and err 0.
- Every non-fault search yields result == target and takes at most WIDTH probes.
- Asynchronous rst mid-search returns immediately to IDLE with every output at its reset value. The in-progress search is discarded.

## Timing
- Cycle 0: start is high at a rising edge.
- Cycle 1: PROBE, guess_vld=1, guess = 2^(WIDTH-1).
- Each subsequent PROBE cycle presents the next guess. The comparator path is purely combinational within one cycle.
- done rises in the cycle after the final PROBE cycle. Latency from the start edge to done = probes + 1 cycles, so the maximum is WIDTH+1.
- result, probes and err are valid in the same cycle as done.
- Back-to-back: start in the done cycle is accepted. guess_vld reasserts in the next cycle.

## Test plan
- Target 8 (WIDTH 4), start: guess 8 eq -> done in the 2nd cycle after start, result 8, probes 1, err 0.
- Target 5: guesses 8(gt), 4(lt), 6(gt), 5(eq) -> result 5, probes 4, done at cycle 5.
- Target 0 and target 15: guesses 8,4,2,1 all gt -> result 0, probes 4. Guesses 8,12,14,15 with the last eq -> result 15, probes 4.
- Fault: force cmp_gt=cmp_lt=1 on the 2nd probe of target 5 -> done, err 1, result 0 (the 1st probe gave gt, so acc is 0), probes 2. Repeat with all flags low -> same err behaviour.
- start pulsed during PROBE -> ignored, search completes unchanged. start in the done cycle -> new search begins, guess 8 in the next cycle, err cleared.
- rst asserted asynchronously mid-search (3rd probe) -> all outputs 0 immediately. After release, a new start on target 11 gives guesses 8(lt), 12(gt), 10(lt), 11(eq) and result 11.

Source files
------------

// File: rtl/sar_search.sv
// Successive-approximation search controller driving a magnitude comparator, MSB first.
// Latency start->done = probes+1 cycles (max WIDTH+1); start is ignored while busy.
module sar_search #(
  parameter int WIDTH = 4,
  localparam int PW = $clog2(WIDTH + 1),
  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             cmp_gt_i,
  input  logic             cmp_eq_i,
  input  logic             cmp_lt_i,
  output logic [WIDTH-1:0] guess_o,
  output logic             guess_vld_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [PW-1:0]    probes_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [KW-1:0]    k_q, k_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [PW-1:0]    probes_q, probes_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] trial;
  logic             finish;

  assign trial = acc_q | (WIDTH'(1) << k_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      probes_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      probes_q <= probes_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    probes_d = probes_q;
    err_d    = err_q;
    done_d   = 1'b0;
    finish   = 1'b0;
    case (state_q)
      PROBE: begin
        cnt_d = cnt_q + PW'(1);
        case ({cmp_gt_i, cmp_eq_i, cmp_lt_i})
          3'b010: begin
            result_d = trial;
            finish   = 1'b1;
          end
          3'b100, 3'b001: begin
            // lt keeps the trial bit, gt drops it
            if (cmp_lt_i) acc_d = trial;
            if (k_q == '0) begin
              result_d = cmp_lt_i ? trial : acc_q;
              finish   = 1'b1;
            end else begin
              k_d = k_q - KW'(1);
            end
          end
          default: begin
            err_d    = 1'b1;
            result_d = acc_q;
            finish   = 1'b1;
          end
        endcase
        if (finish) begin
          state_d  = DONE;
          done_d   = 1'b1;
          probes_d = cnt_q + PW'(1);
        end
      end
      default: begin
        if (start_i) begin
          state_d  = PROBE;
          acc_d    = '0;
          k_d      = KW'(WIDTH - 1);
          cnt_d    = '0;
          result_d = '0;
          probes_d = '0;
          err_d    = 1'b0;
        end
      end
    endcase
  end

  assign guess_o     = (state_q == PROBE) ? trial : '0;
  assign guess_vld_o = (state_q == PROBE);
  assign busy_o      = (state_q == PROBE);
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign probes_o    = probes_q;
  assign err_o       = err_q;

endmodule
